// File: rtl/universal_ring_shift_reg.sv
// Universal shift register: ring, twisted-ring and linear shifting in either
// direction, with parallel load, hold mode and a step counter with wrap pulse.
module universal_ring_shift_reg #(
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             serial_out,
  output logic [CNT_W-1:0] step_count,
  output logic             wrap
);

  localparam logic [1:0] M_RING  = 2'b00;
  localparam logic [1:0] M_TWIST = 2'b01;
  localparam logic [1:0] M_LIN   = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_W  = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0] LAST_2W = CNT_W'(2*WIDTH-1);

  logic             leaving;
  logic             fill;
  logic             do_shift;
  logic [CNT_W-1:0] last;
  logic [WIDTH-1:0] nxt;

  assign leaving    = dir ? out_data[0] : out_data[WIDTH-1];
  assign serial_out = leaving;
  assign do_shift   = en && (mode != M_HOLD);

  always_comb begin
    fill = serial_in;
    last = LAST_W;
    unique case (mode)
      M_RING:  fill = leaving;
      M_TWIST: begin
        fill = ~leaving;
        last = LAST_2W;
      end
      M_LIN:   fill = serial_in;
      M_HOLD:  fill = serial_in;
      default: fill = serial_in;
    endcase
  end

  always_comb begin
    nxt = out_data;
    if (dir) nxt = {fill, out_data[WIDTH-1:1]};
    else     nxt = {out_data[WIDTH-2:0], fill};
  end

  // The >= compare lets a mode switch to a shorter period wrap cleanly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data   <= '0;
      step_count <= '0;
      wrap       <= 1'b0;
    end else if (load) begin
      out_data   <= load_data;
      step_count <= '0;
      wrap       <= 1'b0;
    end else if (do_shift) begin
      out_data <= nxt;
      if (step_count >= last) begin
        step_count <= '0;
        wrap       <= 1'b1;
      end else begin
        step_count <= step_count + 1'b1;
        wrap       <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_universal_ring_shift_reg.sv
// Bench for universal_ring_shift_reg: directed scenarios plus random
// stimulus, checked against a bit-queue reference model.
module tb_universal_ring_shift_reg;

  localparam int W  = 6;
  localparam int CW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          reset, en, load, dir, serial_in;
  logic [1:0]    mode;
  logic [W-1:0]  load_data;
  logic [W-1:0]  out_data;
  logic          serial_out;
  logic [CW-1:0] step_count;
  logic          wrap;

  int n_chk  = 0;
  int n_fail = 0;

  bit mq[$];
  int mcnt;
  bit mwrap;

  always #5 clk = ~clk;

  universal_ring_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .load_data(load_data), .dir(dir), .mode(mode),
    .serial_in(serial_in), .out_data(out_data),
    .serial_out(serial_out), .step_count(step_count), .wrap(wrap)
  );

  function automatic logic [W-1:0] mval();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = mq[i];
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit o, f;
    int p;
    if (!reset) begin
      mq.delete();
      for (int i = 0; i < W; i++) mq.push_back(1'b0);
      mcnt = 0; mwrap = 0;
    end else if (load) begin
      mq.delete();
      for (int i = 0; i < W; i++) mq.push_back(load_data[i]);
      mcnt = 0; mwrap = 0;
    end else if (en && mode != 2'b11) begin
      p = (mode == 2'b01) ? 2*W : W;
      if (!dir) o = mq.pop_back();
      else      o = mq.pop_front();
      f = (mode == 2'b00) ? o : (mode == 2'b01) ? !o : serial_in;
      if (!dir) mq.push_front(f);
      else      mq.push_back(f);
      if (mcnt >= p - 1) begin mcnt = 0; mwrap = 1; end
      else begin mcnt++; mwrap = 0; end
    end else begin
      mwrap = 0;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("out_data", 32'(out_data), 32'(mval()));
    chk("step_count", 32'(step_count), 32'(mcnt));
    chk("wrap", 32'(wrap), 32'(mwrap));
    chk("serial_out", 32'(serial_out),
        32'(dir ? mq[0] : mq[W-1]));
  endtask

  task automatic do_reset();
    reset = 1'b0; cyc(); reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ring_l [6];
    logic [W-1:0] john [12];
    ring_l = '{6'b000010, 6'b000100, 6'b001000,
               6'b010000, 6'b100000, 6'b000001};
    john = '{6'b000001, 6'b000011, 6'b000111, 6'b001111,
             6'b011111, 6'b111111, 6'b111110, 6'b111100,
             6'b111000, 6'b110000, 6'b100000, 6'b000000};
    for (int i = 0; i < W; i++) mq.push_back(1'b0);
    mcnt = 0; mwrap = 0;
    reset = 1'b0; en = 1'b1; load = 1'b1; dir = 1'b0;
    mode = 2'b00; serial_in = 1'b0; load_data = 6'b111111;
    @(posedge clk); #1;
    cyc(); cyc();
    chk("reset_out", 32'(out_data), 32'd0);
    chk("reset_cnt", 32'(step_count), 32'd0);

    reset = 1'b1; load = 1'b1; load_data = 6'b000001; cyc();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ring_left", 32'(out_data), 32'(ring_l[i]));
      chk("ring_wrap", 32'(wrap), 32'(i == 5));
      chk("ring_cnt", 32'(step_count), 32'((i + 1) % 6));
    end

    do_reset();
    mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("johnson", 32'(out_data), 32'(john[i]));
      chk("john_wrap", 32'(wrap), 32'(i == 11));
    end

    load = 1'b1; load_data = 6'b100000; cyc();
    load = 1'b0; mode = 2'b00; dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ring_right", 32'(out_data), 32'(6'b100000 >> ((i + 1) % 6)));
    end

    do_reset();
    mode = 2'b10; dir = 1'b0; serial_in = 1'b1;
    repeat (3) cyc();
    chk("lin_fill", 32'(out_data), 32'(6'b000111));
    chk("lin_sout", 32'(serial_out), 32'd0);
    serial_in = 1'b0;
    repeat (3) cyc();
    chk("lin_sout_pre", 32'(serial_out), 32'd1);
    cyc();
    chk("lin_drain", 32'(out_data), 32'(6'b110000));

    load = 1'b1; en = 1'b1; load_data = 6'b101010; cyc();
    chk("load_pri", 32'(out_data), 32'(6'b101010));
    chk("load_cnt", 32'(step_count), 32'd0);
    reset = 1'b0; cyc();
    chk("reset_pri", 32'(out_data), 32'd0);
    reset = 1'b1; load_data = 6'b011001; cyc();
    load = 1'b0; mode = 2'b01; cyc();
    mode = 2'b11;
    repeat (5) begin
      cyc();
      chk("hold_out", 32'(out_data), 32'(6'b110011));
      chk("hold_cnt", 32'(step_count), 32'd1);
      chk("hold_wrap", 32'(wrap), 32'd0);
    end

    do_reset();
    mode = 2'b01; dir = 1'b0;
    repeat (9) cyc();
    chk("sw_cnt9", 32'(step_count), 32'd9);
    mode = 2'b00; cyc();
    chk("sw_cnt0", 32'(step_count), 32'd0);
    chk("sw_wrap", 32'(wrap), 32'd1);
    cyc();
    chk("sw_cnt1", 32'(step_count), 32'd1);
    chk("sw_wrap_off", 32'(wrap), 32'd0);

    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 31) != 0);
      load      = ($urandom_range(0, 9) == 0);
      en        = ($urandom_range(0, 3) != 0);
      dir       = 1'($urandom);
      mode      = 2'($urandom);
      serial_in = 1'($urandom);
      load_data = W'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
